// File: rtl/wide_add_pkg.sv
// wide_add_pkg: shared state type, byte width and index sizing for wide_add_sequencer
package wide_add_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int BYTE_W = 8;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/byte_adder.sv
// byte_adder: combinational 8-bit adder exposing carry into and out of bit 7
module byte_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co,
  output logic       c7
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {8'd0, ci};
  assign c7 = s[7] ^ a[7] ^ b[7];
endmodule

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: byte-serial wide adder, one shared byte_adder; WIDE_ADD_SUB_EN adds op (subtract)
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  input  logic                     cin,
`ifdef WIDE_ADD_SUB_EN
  input  logic                     op,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W*NBYTES-1:0] sum,
  output logic                     cout,
  output logic                     ovf,
  output logic                     busy
);
  localparam int W  = BYTE_W * NBYTES;
  localparam int IW = idx_w(NBYTES);
  state_t state, nxt;
  logic [W-1:0] a_r, b_r;
  logic [IW-1:0] idx;
  logic carry, sub, sub_in, acc, last;
  logic [BYTE_W-1:0] ba, bb, bs;
  logic bco, bc7;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign acc       = in_valid && in_ready;
  assign last      = idx == IW'(NBYTES - 1);
  always_comb begin
    nxt = state;
    nxt = (state == IDLE) ? (in_valid ? RUN : IDLE) :
          (state == RUN)  ? (last ? DONE : RUN) :
                            (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
`ifdef WIDE_ADD_SUB_EN
  assign sub_in = op;
  always_ff @(posedge clk) sub <= rst ? 1'b0 : acc ? op : sub;
`else
  assign sub_in = 1'b0;
  assign sub    = 1'b0;
`endif
  // subtract is a + ~b + 1: invert b slices, the +1 rides in on the initial carry
  assign ba = a_r[BYTE_W*idx +: BYTE_W];
  assign bb = b_r[BYTE_W*idx +: BYTE_W] ^ {BYTE_W{sub}};
  byte_adder u_add (.a(ba), .b(bb), .ci(carry), .s(bs), .co(bco), .c7(bc7));
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      idx   <= '0;
      carry <= 1'b0;
    end else if (acc) begin
      a_r   <= a;
      b_r   <= b;
      idx   <= '0;
      carry <= sub_in | cin;
    end else if (state == RUN) begin
      sum[BYTE_W*idx +: BYTE_W] <= bs;
      carry <= bco;
      idx   <= last ? idx : idx + 1'b1;
      if (last) begin
        cout <= bco;
        ovf  <= bc7 ^ bco;
      end
    end
  end
endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb_wide_add_sequencer: directed self-checking bench for wide_add_sequencer at NBYTES=4
module tb_wide_add_sequencer;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, cin = 0;
  logic [31:0] a = 0, b = 0, sum;
  logic in_ready, out_valid, cout, ovf, busy;
`ifdef WIDE_ADD_SUB_EN
  logic op = 0;
`endif
  int checks = 0, errors = 0;

  wide_add_sequencer #(.NBYTES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef WIDE_ADD_SUB_EN
    .op(op),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [31:0] av, input logic [31:0] bv, input logic c);
    @(negedge clk);
    a = av; b = bv; cin = c; in_valid = 1;
    chk("ready_before_accept", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic wait_done(input string tag);
    int lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    chk({tag, "_latency"}, lat, 4);
  endtask

  task automatic result(input string tag, input logic [31:0] s, input logic co, input logic ov);
    chk({tag, "_sum"}, sum, s);
    chk({tag, "_cout"}, cout, co);
    chk({tag, "_ovf"}, ovf, ov);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    @(negedge clk);
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_ready_back"}, in_ready, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    result("rst", 32'h0, 0, 0);

    launch(32'h000000FF, 32'h00000001, 0);
    chk("run_busy", busy, 1);
    wait_done("t1");
    result("t1", 32'h00000100, 0, 0);
    handshake("t1");

    launch(32'hFFFFFFFF, 32'h00000000, 1);
    wait_done("t2");
    result("t2", 32'h00000000, 1, 0);
    handshake("t2");

    launch(32'h7FFFFFFF, 32'h00000001, 0);
    wait_done("t3");
    result("t3", 32'h80000000, 0, 1);
    handshake("t3");

    launch(32'h00000003, 32'h00000004, 0);
    wait_done("t4");
    result("t4", 32'h00000007, 0, 0);
    a = 32'h10000000; b = 32'h20000000; cin = 0; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_sum", sum, 32'h00000007);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    chk("hs_idle_ready", in_ready, 1);
    chk("hs_idle_busy", busy, 0);
    @(posedge clk);
    #1 in_valid = 0;
    chk("late_accept_busy", busy, 1);
    wait_done("t5");
    result("t5", 32'h30000000, 0, 0);
    handshake("t5");

    launch(32'hFFFFFFFF, 32'h00000001, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    result("mid_rst", 32'h0, 0, 0);
    @(negedge clk);
    chk("mid_rst_stays_idle", busy, 0);
    launch(32'h12345678, 32'h11111111, 0);
    wait_done("t6");
    result("t6", 32'h23456789, 0, 0);
    handshake("t6");

`ifdef WIDE_ADD_SUB_EN
    op = 1;
    launch(32'h00000005, 32'h00000007, 0);
    op = 0;
    wait_done("sub");
    result("sub", 32'hFFFFFFFE, 0, 0);
    handshake("sub");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wide_add_sequencer.md
WIDE_ADD_SEQUENCER -- requirements
Module: wide_add_sequencer

Interface
REQ-001 The block SHALL have parameter NBYTES, default 4, giving the number of bytes per operand (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the request holds valid operands.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the sequencer can accept a request.
REQ-006 The block SHALL have ports a and b, input, 8*NBYTES bits each: the operands.
REQ-007 The block SHALL have port cin, input, 1 bit: the carry-in of the whole operation.
REQ-008 The block SHALL have port op, input, 1 bit, present only when WIDE_ADD_SUB_EN is defined: 0 selects add, 1 selects subtract.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is available.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port sum, output, 8*NBYTES bits: the result.
REQ-012 The block SHALL have port cout, output, 1 bit: carry out of the most significant byte.
REQ-013 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 The block SHALL implement the states IDLE, RUN and DONE.
REQ-016 The block SHALL drive in_ready = 1 only in IDLE; a request is accepted on a clock edge where in_valid && in_ready.
REQ-017 On acceptance, the block SHALL:
- latch a, b, cin (and op);
- clear the byte index idx to 0;
- move to RUN.
REQ-018 In RUN, each cycle the block SHALL:
- drive one byte slice (idx) through the byte adder, with carry-in = the carry register (cin on idx 0);
- write the byte into sum[8*idx +: 8];
- update the carry register;
- increment idx.
REQ-019 When idx == NBYTES-1 in RUN, the block SHALL move to DONE; out_valid SHALL rise exactly NBYTES cycles after the acceptance edge.
REQ-020 In DONE, the block SHALL hold out_valid, sum, cout and ovf stable until out_ready is high, then return to IDLE on that edge.
REQ-021 The earliest next acceptance SHALL be one cycle after the DONE handshake; throughput is 1 operation per NBYTES+2 cycles.
REQ-022 The block SHALL set cout = carry out of byte NBYTES-1.
REQ-023 The block SHALL compute ovf = carry into the MSB XOR carry out of the MSB, captured during the final byte.
REQ-024 The block SHALL ignore in_valid outside IDLE: no state change and no operand overwrite.
REQ-025 Result registers SHALL keep their last value in IDLE; only out_valid qualifies them.
REQ-026 Carry SHALL wrap naturally: the sum is modulo 2^(8*NBYTES), with overflow reported only through cout and ovf.

Reset
REQ-027 When rst is high at a clock edge, in any state including mid-RUN, the block SHALL:
- go to IDLE;
- set in_ready=1, out_valid=0, busy=0;
- clear sum, cout, ovf, idx and the carry register to 0;
- discard any partial result.
REQ-028 rst SHALL have priority over every handshake occurring in the same cycle.

Configuration
REQ-029 When the macro WIDE_ADD_SUB_EN is defined, port op SHALL exist, and op=1 SHALL:
- invert each b byte before the byte adder;
- force the byte-0 carry-in to 1 (cin ignored);
- make cout = NOT borrow.
REQ-030 When WIDE_ADD_SUB_EN is undefined, port op SHALL be absent and the block SHALL perform add only.

Structure
REQ-031 The package wide_add_pkg SHALL hold:
- the state enum type (IDLE, RUN, DONE);
- the byte width constant BYTE_W = 8;
- the index width function clog2-based on NBYTES.
REQ-032 Exactly one sub-module, byte_adder, SHALL exist: combinational, 8-bit a, b, ci, producing 8-bit s, co, and c7 (carry into bit 7); it SHALL be instanced once and time-shared across byte slices.

Verification (NBYTES=4)
REQ-033 a=0x000000FF, b=0x00000001, cin=0 -> sum=0x00000100, cout=0, ovf=0, with out_valid exactly 4 cycles after acceptance.
REQ-034 a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1, ovf=0.
REQ-035 a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1.
REQ-036 Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> sum, out_valid and in_ready=0 stay stable; the new request is accepted only after the handshake plus 1 cycle.
REQ-037 Assert rst for 1 cycle at idx=2 of a RUN -> the next cycle shows IDLE, in_ready=1, out_valid=0, sum=0; a following request 0x12345678+0x11111111 -> 0x23456789.
REQ-038 With WIDE_ADD_SUB_EN defined: a=0x00000005, b=0x00000007, op=1 -> sum=0xFFFFFFFE, cout=0, ovf=0.
